// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and the default
// address/data widths used by the PC, fetch and decode.
package fetch_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Free-running fetch statistics: completed decode handshakes and memory wait
// cycles. Both counters wrap and are cleared only by reset.
module fetch_perf_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        handshake,
    input  logic        stall,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
);

    logic [1:0]       inc;
    logic [1:0][15:0] count_vec;

    assign inc = {stall, handshake};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (inc[gi]) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end

            assign count_vec[gi] = cnt_reg;
        end
    endgenerate

    assign fetch_count = count_vec[0];
    assign stall_count = count_vec[1];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: samples the PC, reads instruction memory over req/ack, and holds
// the word for decode over valid/ready. Define FETCH_PERF_CNT_EN for counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_incr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count,
`endif
    input  logic              flush
);

    fetch_state_t      state_reg;
    logic              drop_reg;
    logic              pc_incr_reg;
    logic              mem_req_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [ADDR_W-1:0] ir_pc_reg;
    logic              ir_valid_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            drop_reg     <= 1'b0;
            pc_incr_reg  <= 1'b0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            ir_reg       <= '0;
            ir_pc_reg    <= '0;
            ir_valid_reg <= 1'b0;
        end else begin
            pc_incr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!flush) begin
                        mem_addr_reg <= pc_in;
                        mem_req_reg  <= 1'b1;
                        state_reg    <= REQ;
                    end
                end
                REQ: begin
                    // A request cannot be withdrawn; a flush only poisons its response.
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        drop_reg    <= 1'b0;
                        if (drop_reg || flush) begin
                            state_reg <= IDLE;
                        end else begin
                            ir_reg       <= mem_rdata;
                            ir_pc_reg    <= mem_addr_reg;
                            ir_valid_reg <= 1'b1;
                            pc_incr_reg  <= 1'b1;
                            state_reg    <= HOLD;
                        end
                    end else if (flush) begin
                        drop_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        ir_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end else if (ir_ready) begin
                        ir_valid_reg <= 1'b0;
                        mem_addr_reg <= pc_in;
                        mem_req_reg  <= 1'b1;
                        state_reg    <= REQ;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pc_incr  = pc_incr_reg;
    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = ir_valid_reg;

`ifdef FETCH_PERF_CNT_EN
    logic handshake;
    logic stall;

    assign handshake = (state_reg == HOLD) && ir_ready && !flush;
    assign stall     = (state_reg == REQ) && !mem_ack;

    fetch_perf_cnt u_perf_cnt (
        .clock       (clock),
        .reset       (reset),
        .handshake   (handshake),
        .stall       (stall),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule
